// File: rtl/priority_encoder.sv
// priority_encoder: captures 8 request lines into a pending mask and presents one
// encoded index at a time over a valid/ready handshake.
//   RR_MODE    : 0 = fixed priority (index 7 highest), 1 = round-robin
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : active-low chip enable; gates capture and new loads
//   din        : request lines, one per source index
//   dout       : encoded index being presented
//   dout_valid : dout holds a valid index
//   dout_ready : consumer accepts dout this cycle
//   pending    : captured, not-yet-accepted requests
//   overflow   : sticky, a request hit an already-pending bit
module priority_encoder #(
    parameter int unsigned RR_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] din,
    output logic [2:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  dout_nx;
    logic           dout_valid_nx;
    logic [W-1:0]   pending_nx;
    logic           overflow_nx;
    logic [IW-1:0]  last, last_nx;

    logic           xfer_c;
    logic [W-1:0]   clr_c;
    logic [W-1:0]   set_c;
    logic [W-1:0]   cand_c;
    logic [IW-1:0]  base_c;
    logic [IW-1:0]  probe_c;
    logic [IW-1:0]  sel_idx_c;
    logic           sel_any_c;

    // Handshake and per-cycle set/clear masks; the search excludes the bit leaving now
    always_comb begin : masks_p
        xfer_c = dout_valid & dout_ready;
        clr_c  = xfer_c ? (W'(1) << dout) : '0;
        set_c  = enable ? '0 : din;
        cand_c = pending & ~clr_c;
        base_c = xfer_c ? dout : last;
    end

    // Index selection over cand_c; later loop iterations override earlier ones
    always_comb begin : select_p
        sel_any_c = 1'b0;
        sel_idx_c = '0;
        probe_c   = '0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < int'(W); i++) begin
                if (cand_c[i]) begin
                    sel_any_c = 1'b1;
                    sel_idx_c = IW'(i);
                end
            end
        end else begin
            // k = 8 truncates to base itself, so the base index is searched last
            for (int k = int'(W); k >= 1; k--) begin
                probe_c = base_c + IW'(k);
                if (cand_c[probe_c]) begin
                    sel_any_c = 1'b1;
                    sel_idx_c = probe_c;
                end
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin : next_p
        state_nx      = state;
        dout_nx       = dout;
        dout_valid_nx = dout_valid;
        last_nx       = last;
        // set wins over clear on a collision, and a colliding set is not an overflow
        pending_nx    = (pending & ~clr_c) | set_c;
        overflow_nx   = overflow | (|(set_c & pending & ~clr_c));
        case (state)
            IDLE: begin
                if (!enable && sel_any_c) begin
                    state_nx      = PRESENT;
                    dout_nx       = sel_idx_c;
                    dout_valid_nx = 1'b1;
                end
            end
            PRESENT: begin
                if (xfer_c) begin
                    last_nx = dout;
                    if (!enable && sel_any_c) begin
                        dout_nx = sel_idx_c;
                    end else begin
                        state_nx      = IDLE;
                        dout_valid_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx      = IDLE;
                dout_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin : regs_p
        if (!rst_n) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            pending    <= '0;
            overflow   <= 1'b0;
            last       <= IW'(7);
        end else begin
            state      <= state_nx;
            dout       <= dout_nx;
            dout_valid <= dout_valid_nx;
            pending    <= pending_nx;
            overflow   <= overflow_nx;
            last       <= last_nx;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: runs a fixed-priority and a round-robin instance side by side
// on shared stimulus, scoreboarding every accepted index against a request-level model.
module tb_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] din;
    logic       dout_ready;

    logic [2:0] dout_f, dout_r;
    logic       dv_f, dv_r;
    logic [7:0] pend_f, pend_r;
    logic       ovf_f, ovf_r;

    int checks = 0;
    int errors = 0;

    priority_encoder #(.RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din),
        .dout(dout_f), .dout_valid(dv_f), .dout_ready(dout_ready),
        .pending(pend_f), .overflow(ovf_f)
    );

    priority_encoder #(.RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din),
        .dout(dout_r), .dout_valid(dv_r), .dout_ready(dout_ready),
        .pending(pend_r), .overflow(ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request set, presented item, pointer, sticky flag
    typedef struct packed {
        logic [7:0] pend;
        logic [2:0] dout;
        logic [2:0] last;
        logic       val;
        logic       ovf;
    } model_t;

    localparam model_t M_RST = '{pend: 8'h00, dout: 3'd0, last: 3'd7, val: 1'b0, ovf: 1'b0};

    model_t m0, m1;
    int q0[$];
    int q1[$];
    int e0, e1;

    function automatic model_t step(input model_t s, input int mode);
        model_t     n;
        logic       xfer;
        logic [7:0] clr, set, cand;
        int         base, idx;
        n    = s;
        xfer = s.val && dout_ready;
        clr  = 8'h00;
        if (xfer) clr[s.dout] = 1'b1;
        set  = enable ? 8'h00 : din;
        if ((set & s.pend & ~clr) != 8'h00) n.ovf = 1'b1;
        n.pend = (s.pend & ~clr) | set;
        if (xfer) n.last = s.dout;
        if (!s.val || xfer) begin
            cand = s.pend & ~clr;
            if (!enable && cand != 8'h00) begin
                base = xfer ? int'(s.dout) : int'(s.last);
                idx  = -1;
                if (mode == 0) begin
                    for (int i = 7; i >= 0; i--) begin
                        if (idx < 0 && cand[i]) idx = i;
                    end
                end else begin
                    for (int k = 1; k <= 8; k++) begin
                        if (idx < 0 && cand[(base + k) % 8]) idx = (base + k) % 8;
                    end
                end
                n.dout = 3'(idx);
                n.val  = 1'b1;
                if (mode == 0) q0.push_back(idx);
                else           q1.push_back(idx);
            end else begin
                n.val = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= M_RST;
            m1 <= M_RST;
            q0.delete();
            q1.delete();
        end else begin
            m0 <= step(m0, 0);
            m1 <= step(m1, 1);
        end
    end

    // Monitor: state compare every cycle, pop expected index on every transfer
    always @(negedge clk) begin
        chk("pend_f", int'(pend_f), int'(m0.pend));
        chk("ovf_f", int'(ovf_f), int'(m0.ovf));
        chk("valid_f", int'(dv_f), int'(m0.val));
        chk("pend_r", int'(pend_r), int'(m1.pend));
        chk("ovf_r", int'(ovf_r), int'(m1.ovf));
        chk("valid_r", int'(dv_r), int'(m1.val));
        if (dv_f && dout_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL xfer_f: got %0d expected none (queue empty)", dout_f);
            end else begin
                e0 = q0.pop_front();
                chk("xfer_f", int'(dout_f), e0);
            end
        end
        if (dv_r && dout_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL xfer_r: got %0d expected none (queue empty)", dout_r);
            end else begin
                e1 = q1.pop_front();
                chk("xfer_r", int'(dout_r), e1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din        = 8'h00;
        enable     = 1'b0;
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout_f"}, int'(dout_f), 0);
        chk({tag, "_dv_f"}, int'(dv_f), 0);
        chk({tag, "_pend_f"}, int'(pend_f), 0);
        chk({tag, "_ovf_f"}, int'(ovf_f), 0);
        chk({tag, "_dout_r"}, int'(dout_r), 0);
        chk({tag, "_dv_r"}, int'(dv_r), 0);
        chk({tag, "_pend_r"}, int'(pend_r), 0);
        chk({tag, "_ovf_r"}, int'(ovf_r), 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; din = 8'h00; dout_ready = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fixed 8'h12 one-cycle pulse with ready held high
        dout_ready = 1'b1; din = 8'h12;
        tick();
        din = 8'h00;
        chk("f028_pend_n1", int'(pend_f), 8'h12);
        chk("f028_dv_n1", int'(dv_f), 0);
        tick();
        chk("f028_dv_n2", int'(dv_f), 1);
        chk("f028_dout_n2", int'(dout_f), 4);
        chk("r028_dout_n2", int'(dout_r), 1);
        tick();
        chk("f028_dout_n3", int'(dout_f), 1);
        chk("r028_dout_n3", int'(dout_r), 4);
        tick();
        chk("f028_dv_n4", int'(dv_f), 0);
        chk("f028_pend_n4", int'(pend_f), 0);
        do_reset();

        // Backpressure: index 7 held while index 0 keeps arriving
        din = 8'h80;
        tick();
        din = 8'h01;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("f029_hold_dout", int'(dout_f), 7);
            chk("f029_hold_dv", int'(dv_f), 1);
            chk("r029_hold_dout", int'(dout_r), 7);
            tick();
        end
        dout_ready = 1'b1; din = 8'h00;
        tick();
        chk("f029_next_dout", int'(dout_f), 0);
        chk("f029_next_dv", int'(dv_f), 1);
        chk("r029_next_dout", int'(dout_r), 0);
        tick();
        do_reset();

        // Round-robin sweep of all eight, then wrap to index 0
        din = 8'hFF; dout_ready = 1'b1;
        tick();
        din = 8'h00;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("r030_seq", int'(dout_r), i);
            chk("r030_dv", int'(dv_r), 1);
            chk("f030_seq", int'(dout_f), 7 - i);
            tick();
        end
        chk("r030_drop", int'(dv_r), 0);
        din = 8'h01;
        tick();
        din = 8'h00;
        tick();
        chk("r030_wrap", int'(dout_r), 0);
        chk("r030_wrap_dv", int'(dv_r), 1);
        tick();
        do_reset();

        // Overflow on repeated request without transfer
        din = 8'h08;
        tick();
        chk("f031_ovf_pre", int'(ovf_f), 0);
        tick();
        chk("f031_ovf", int'(ovf_f), 1);
        chk("r031_ovf", int'(ovf_r), 1);
        din = 8'h00; dout_ready = 1'b1;
        tick(); tick();
        chk("f031_ovf_sticky", int'(ovf_f), 1);
        do_reset();

        // Set/clear collision on the transferring index
        din = 8'h20;
        tick();
        din = 8'h00;
        tick();
        chk("f031_col_dout", int'(dout_f), 5);
        dout_ready = 1'b1; din = 8'h20;
        tick();
        din = 8'h00;
        chk("f031_col_pend5", int'(pend_f[5]), 1);
        chk("f031_col_ovf", int'(ovf_f), 0);
        chk("f031_col_dv", int'(dv_f), 0);
        tick();
        chk("f031_col_again", int'(dout_f), 5);
        chk("f031_col_again_dv", int'(dv_f), 1);
        tick(); tick();
        do_reset();

        // Disabled requests are ignored
        enable = 1'b1; din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f032_dis_pend", int'(pend_f), 0);
            chk("f032_dis_dv", int'(dv_f), 0);
        end
        enable = 1'b0; din = 8'h00;
        tick();

        // Reset mid-presentation clears everything at once
        din = 8'h04; dout_ready = 1'b0;
        tick();
        din = 8'h00;
        tick();
        chk("f032_pre_dv", int'(dv_f), 1);
        chk("f032_pre_dout", int'(dout_f), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("f032_post_dv", int'(dv_f), 0);
        chk("f032_post_pend", int'(pend_f), 0);

        // Randomized traffic, periodic resets to re-arm the sticky flag
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 499) begin
                do_reset();
            end else begin
                din        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                enable     = ($urandom_range(0, 4) == 0);
                dout_ready = ($urandom_range(0, 9) < 6);
                tick();
            end
        end
        din = 8'h00; enable = 1'b0; dout_ready = 1'b1;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
